// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding, operator
// codes and the (row, col) -> key class / value lookup.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_SCAN     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_EMIT     = 3'd2,
        ST_HOLD     = 3'd3,
        ST_RELEASE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        KC_NUM = 2'd0,
        KC_OP  = 2'd1,
        KC_CLR = 2'd2,
        KC_EQ  = 2'd3
    } key_class_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Layout: r0 "1 2 3 +", r1 "4 5 6 -", r2 "7 8 9 *", r3 "C 0 = /"
    function automatic key_class_e key_class(input logic [1:0] row, input logic [1:0] col);
        key_class_e kc;
        case ({row, col})
            4'h3, 4'h7, 4'hB, 4'hF: kc = KC_OP;
            4'hC:                   kc = KC_CLR;
            4'hE:                   kc = KC_EQ;
            default:                kc = KC_NUM;
        endcase
        return kc;
    endfunction

    // Digit value for digit keys, operator code (low bits) for operator keys.
    function automatic logic [3:0] key_value(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] v;
        case ({row, col})
            4'h0:    v = 4'd1;
            4'h1:    v = 4'd2;
            4'h2:    v = 4'd3;
            4'h3:    v = {2'b00, OP_ADD};
            4'h4:    v = 4'd4;
            4'h5:    v = 4'd5;
            4'h6:    v = 4'd6;
            4'h7:    v = {2'b00, OP_SUB};
            4'h8:    v = 4'd7;
            4'h9:    v = 4'd8;
            4'hA:    v = 4'd9;
            4'hB:    v = {2'b00, OP_MUL};
            4'hF:    v = {2'b00, OP_DIV};
            default: v = 4'd0;
        endcase
        return v;
    endfunction

    function automatic logic single_low(input logic [3:0] rows_n);
        logic one;
        case (rows_n)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one = 1'b1;
            default:                            one = 1'b0;
        endcase
        return one;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows_n);
        logic [1:0] idx;
        case (rows_n)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// Two-flop synchroniser for the asynchronous keypad row lines; idles high
// (no key) out of reset.
module keypad_sync (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] async_i,
    output logic [3:0] sync_o
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    // Two-stage shift into the clk domain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad front end: debounces one key press and emits a
// single registered num/OP/C/EQ pulse per accepted press.
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       num,
    output logic       OP,
    output logic       C,
    output logic       EQ,
    output logic [3:0] key_val,
    output logic [1:0] op_val,
    output logic [2:0] scan_state
);
    import keypad_pkg::*;

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CNT - 1);

    state_e        state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;
    logic [3:0]    col_n_q, col_n_d;
    logic          num_q, num_d, op_q, op_d, c_q, c_d, eq_q, eq_d;
    logic [3:0]    key_val_q, key_val_d;
    logic [1:0]    op_val_q, op_val_d;

    logic [3:0]    rs_s;
    logic          latched_low_s;
    logic [3:0]    lookup_val_s;
    key_class_e    lookup_class_s;

    keypad_sync u_sync (
        .clk    (clk),
        .resetn (resetn),
        .async_i(row_n),
        .sync_o (rs_s)
    );

    assign latched_low_s  = ~rs_s[row_q];
    assign lookup_val_s   = key_value(row_q, col_q);
    assign lookup_class_s = key_class(row_q, col_q);

    // Next-state, counter, decode and pulse logic.
    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        num_d     = 1'b0;
        op_d      = 1'b0;
        c_d       = 1'b0;
        eq_d      = 1'b0;
        key_val_d = key_val_q;
        op_val_d  = op_val_q;
        case (state_q)
            ST_SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = {DW{1'b0}};
                    // Zero or several rows low on this column: keep scanning.
                    if (single_low(rs_s)) begin
                        row_d   = low_index(rs_s);
                        cnt_d   = {CW{1'b0}};
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!latched_low_s) begin
                    state_d = ST_SCAN;
                    dwell_d = {DW{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_EMIT;
                    case (lookup_class_s)
                        KC_NUM: begin
                            num_d     = 1'b1;
                            key_val_d = lookup_val_s;
                        end
                        KC_OP: begin
                            op_d     = 1'b1;
                            op_val_d = lookup_val_s[1:0];
                        end
                        KC_CLR:  c_d  = 1'b1;
                        KC_EQ:   eq_d = 1'b1;
                        default: num_d = 1'b0;
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_EMIT: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!latched_low_s) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RELEASE: begin
                // A low row here is release bounce: back to HOLD, never a new press.
                if (latched_low_s) begin
                    state_d = ST_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    dwell_d = {DW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_SCAN;
                dwell_d = {DW{1'b0}};
            end
        endcase
        col_n_d = 4'b1111 ^ (4'b0001 << col_d);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_SCAN;
            dwell_q   <= {DW{1'b0}};
            cnt_q     <= {CW{1'b0}};
            col_q     <= 2'd0;
            row_q     <= 2'd0;
            col_n_q   <= 4'b1110;
            num_q     <= 1'b0;
            op_q      <= 1'b0;
            c_q       <= 1'b0;
            eq_q      <= 1'b0;
            key_val_q <= 4'd0;
            op_val_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
            col_n_q   <= col_n_d;
            num_q     <= num_d;
            op_q      <= op_d;
            c_q       <= c_d;
            eq_q      <= eq_d;
            key_val_q <= key_val_d;
            op_val_q  <= op_val_d;
        end
    end

    assign col_n      = col_n_q;
    assign num        = num_q;
    assign OP         = op_q;
    assign C          = c_q;
    assign EQ         = eq_q;
    assign key_val    = key_val_q;
    assign op_val     = op_val_q;
    assign scan_state = state_q;

endmodule
